password_cracker_multi: RTL
===========================

// Module: password_cracker_multi
// PURPOSE
//   Parametrised multi-lane brute-force password cracker. It searches every PW_LEN-character
//   string over the 36-symbol charset '0'-'9','A'-'Z' for a match against a target latched at start.
//   The search space is split across LANES parallel candidate generators; each lane tests one
//   candidate per clock. Adds a start/abort/done handshake, the recovered password and an attempt count.
// PARAMETERS
//   PW_LEN   4   password length in characters, 1..6 (36^6 fits the 32-bit attempt counter)
//   LANES    4   parallel candidate generators, 1..36
// PORTS
//   clk        in   1            single clock, all logic on posedge
//   rst        in   1            synchronous active-high reset
//   start      in   1            launch a search; sampled only in IDLE or DONE
//   abort      in   1            cancel a running search; sampled only in SEARCH
//   target     in   8*PW_LEN     ASCII target, MSB byte = first character; latched on accepted start
//   busy       out  1            high while in SEARCH
//   done       out  1            high in DONE, held until next accepted start or rst
//   found      out  1            valid when done: 1 = match, 0 = space exhausted
//   result     out  8*PW_LEN     matching ASCII string when found, else 0
//   attempts   out  32           candidates compared in the current/last search
// BEHAVIOUR
//   - Charset index i maps to ASCII '0'+i for i<10 and 'A'+(i-10) for 10<=i<=35.
//   - Reset: state=IDLE; busy=0, done=0, found=0, result=0, attempts=0. rst wins over every input.
//   - Reset mid-search returns to IDLE on the same edge; the latched target is discarded.
//   - FSM IDLE -> SEARCH on start. SEARCH -> DONE on match or exhaustion. SEARCH -> IDLE on abort.
//   - FSM DONE -> SEARCH on start. start during SEARCH is ignored. abort outside SEARCH is ignored.
//   - Lane partitioning: lane k owns first-char indices k, k+LANES, k+2*LANES ... <=35.
//     The remaining PW_LEN-1 characters run as an odometer, last char fastest, wrapping 35->0 with carry.
//     Lanes whose first index exceeds 35 (LANES>36 is illegal) never activate.
//   - On an accepted start (edge t), target is latched and each lane is initialised to
//     {k, 0, ..., 0}. attempts is cleared. done, found and result are cleared.
//   - Search cycle n (n=0,1,..) is the cycle after edge t+n. Every still-active lane compares
//     its candidate with the target. attempts increases by the number of active lanes.
//   - A lane goes inactive after its final candidate, i.e. {last owned first idx, 35, ..., 35}.
//     Uneven lanes (36 mod LANES != 0) finish earlier and stop counting.
//   - Match in search cycle n: at edge t+n+1 the FSM enters DONE with done=1, found=1, and
//     result = matching ASCII string. attempts includes the matching cycle.
//     Candidates are disjoint, so at most one lane can match per cycle.
//   - Exhaustion: the cycle in which the last active lane tests its final candidate without a
//     match leads to DONE with found=0, result=0, and attempts=36^PW_LEN.
//   - Target bytes outside the charset (e.g. lowercase) never match, so the search ends by exhaustion.
//   - Abort in search cycle n: the FSM goes to IDLE at the next edge with done=0. attempts holds
//     the value including cycle n. No compare result from cycle n is reported.
//   - busy and done are never high together. Outputs are registered, with no combinational input->output path.
// TESTING
//   1 PW_LEN=4, LANES=4, target "0001", start -> match in search cycle 1; done=1, found=1 at
//     start edge+2; result="0001", attempts=8.
//   2 PW_LEN=2, LANES=4, target "ZZ" -> lane 3, n=323; found=1, result="ZZ", attempts=1296
//     (last candidate of the space).
//   3 PW_LEN=2, LANES=4, target "a0" -> exhaustion; done=1, found=0, result=0, attempts=1296,
//     busy high for exactly 324 cycles.
//   4 PW_LEN=2, LANES=5, target "Z0" -> lane 0 (index 35 = 0+7*5), n=7*36=252; found=1.
//     Lanes 1-4 go inactive after 252 cycles, so attempts=252*5+1=1261.
//   5 Start "55" (PW_LEN=2, LANES=1). Assert abort at search cycle 10 -> IDLE, done=0, attempts=11.
//     Then a new start finds "55" at n=185 with attempts=186.
//   6 rst asserted mid-search -> all outputs 0 next edge. start while busy is ignored (target unchanged).
//     start from DONE relaunches and clears found/result.

Source files
------------

// File: rtl/password_cracker_multi.sv
// Multi-lane brute-force password cracker over the charset '0'-'9','A'-'Z'.
// Lane k walks first-char indices k, k+LANES, ...; the rest of the string runs as a base-36 odometer.
module password_cracker_multi #(
  parameter int PW_LEN = 4,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [8*PW_LEN-1:0]   target,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [8*PW_LEN-1:0]   result,
  output logic [31:0]           attempts
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t              state;
  logic [8*PW_LEN-1:0] tgt;
  logic [5:0]          cand       [LANES][PW_LEN];
  logic [5:0]          nxt        [LANES][PW_LEN];
  logic [LANES-1:0]    active;
  logic [LANES-1:0]    nxt_active;
  logic                hit;
  logic [8*PW_LEN-1:0] hit_str;
  logic [31:0]         n_active;

  function automatic logic [7:0] to_ascii(input logic [5:0] i);
    return (i < 6'd10) ? 8'h30 + {2'b00, i} : 8'h37 + {2'b00, i};
  endfunction

  always_comb begin : compare
    logic [8*PW_LEN-1:0] str;
    hit      = 1'b0;
    hit_str  = '0;
    n_active = '0;
    str      = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      for (int unsigned i = 0; i < PW_LEN; i++)
        str[8*(PW_LEN-1-i) +: 8] = to_ascii(cand[k][i]);
      if (active[k]) begin
        n_active = n_active + 32'd1;
        if (str == tgt) begin
          hit     = 1'b1;
          hit_str = str;
        end
      end
    end
  end

  // Odometer on chars 1..PW_LEN-1; a full wrap steps the first char by LANES,
  // and a wrap from the lane's last first-char index retires the lane.
  always_comb begin : advance
    logic carry;
    carry      = 1'b0;
    nxt_active = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      for (int unsigned i = 0; i < PW_LEN; i++)
        nxt[k][i] = cand[k][i];
      carry = 1'b1;
      for (int unsigned i = PW_LEN - 1; i >= 1; i--) begin
        if (carry) begin
          if (cand[k][i] == 6'd35) begin
            nxt[k][i] = '0;
          end else begin
            nxt[k][i] = cand[k][i] + 6'd1;
            carry     = 1'b0;
          end
        end
      end
      if (carry)
        nxt[k][0] = cand[k][0] + 6'(LANES);
      nxt_active[k] = active[k] & ~(carry & (({1'b0, cand[k][0]} + 7'(LANES)) > 7'd35));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      result   <= '0;
      attempts <= '0;
      tgt      <= '0;
      active   <= '0;
      for (int unsigned k = 0; k < LANES; k++)
        for (int unsigned i = 0; i < PW_LEN; i++)
          cand[k][i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SEARCH;
            busy     <= 1'b1;
            done     <= 1'b0;
            found    <= 1'b0;
            result   <= '0;
            attempts <= '0;
            tgt      <= target;
            for (int unsigned k = 0; k < LANES; k++) begin
              active[k] <= (k < 36);
              for (int unsigned i = 0; i < PW_LEN; i++)
                cand[k][i] <= (i == 0) ? 6'(k) : 6'd0;
            end
          end
        end
        SEARCH: begin
          attempts <= attempts + n_active;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (hit) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            found  <= 1'b1;
            result <= hit_str;
          end else if (nxt_active == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            active <= nxt_active;
            cand   <= nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
